load_store_unit: RTL and testbench

- Initiator side of the byte-addressed data RAM.
- Takes load/store requests from the core execute stage and issues word-wide RAM accesses at word-aligned addresses.
- Performs byte/halfword lane extraction with sign or zero extension for loads, and read-modify-write for sub-word stores.
- Returns one response per request over a valid/ready handshake.

---
 rtl/load_store_unit_pkg.sv | 32 +++
 rtl/load_store_unit_lane.sv | 50 +++++
 rtl/load_store_unit.sv | 117 +++++++++++
 tb/tb_load_store_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM states
// and the request legality check.
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RMW_READ,
      WRITE,
      RESP
   } state_t;

   // Width/alignment fault only; the address range check needs SIZE and lives in the top.
   function automatic logic access_fault(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lo);
      case (f3)
         F3_B:    return 1'b0;
         F3_H:    return lo[0];
         F3_W:    return lo != 2'b00;
         F3_BU:   return we;
         F3_HU:   return we | lo[0];
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_lane.sv
// Byte/halfword lane logic: extends a loaded sub-word and merges store data
// into a read-back word. Purely combinational.
module load_store_unit_lane
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] store_data,
   output logic [31:0] load_value,
   output logic [31:0] store_word
);

   logic [7:0]  lanes [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lanes[gi] = word[8*gi +: 8];
   end

   assign byte_sel = lanes[addr_lo];
   assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

   always_comb begin
      load_value = '0;
      case (funct3)
         F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_value = {24'h0, byte_sel};
         F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_value = {16'h0, half_sel};
         F3_W:    load_value = word;
         default: load_value = '0;
      endcase
   end

   always_comb begin
      store_word = word;
      case (funct3)
         F3_B:    store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
         F3_H: begin
            if (addr_lo[1]) store_word[31:16] = store_data[15:0];
            else            store_word[15:0]  = store_data[15:0];
         end
         F3_W:    store_word = store_data;
         default: store_word = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, issues word-aligned RAM
// accesses (read-modify-write for SB/SH) and returns one response.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter  int N      = 32,
   parameter  int SIZE   = 1024,
   localparam int ADDR_W = $clog2(SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [N-1:0]      req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [N-1:0]      resp_rdata,
   output logic              resp_err,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [N-1:0]      ram_wdata,
   input  logic [N-1:0]      ram_rdata
);

   state_t      state_reg;
   logic [2:0]  funct3_reg;
   logic [1:0]  addr_lo_reg;
   logic [N-1:0] wdata_reg;
   logic        req_err;
   logic [N-1:0] load_value;
   logic [N-1:0] store_word;

   assign req_err = access_fault(req_we, req_funct3, req_addr[1:0])
                  | (req_addr >= 32'(SIZE));

   load_store_unit_lane u_lane (
      .word       (ram_rdata),
      .addr_lo    (addr_lo_reg),
      .funct3     (funct3_reg),
      .store_data (wdata_reg),
      .load_value (load_value),
      .store_word (store_word)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         funct3_reg  <= '0;
         addr_lo_reg <= '0;
         wdata_reg   <= '0;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
         ram_we      <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  funct3_reg  <= req_funct3;
                  addr_lo_reg <= req_addr[1:0];
                  wdata_reg   <= req_wdata;
                  req_ready   <= 1'b0;
                  resp_rdata  <= '0;
                  resp_err    <= 1'b0;
                  if (req_err) begin
                     resp_err   <= 1'b1;
                     resp_valid <= 1'b1;
                     state_reg  <= RESP;
                  end else begin
                     // ram_addr must be stable before LOAD/RMW_READ since ram_rdata follows it combinationally
                     ram_addr <= {req_addr[ADDR_W-1:2], 2'b00};
                     if (!req_we) begin
                        state_reg <= LOAD;
                     end else if (req_funct3 == F3_W) begin
                        ram_we    <= 1'b1;
                        ram_wdata <= req_wdata;
                        state_reg <= WRITE;
                     end else begin
                        state_reg <= RMW_READ;
                     end
                  end
               end
            end
            LOAD: begin
               resp_rdata <= load_value;
               resp_valid <= 1'b1;
               state_reg  <= RESP;
            end
            RMW_READ: begin
               ram_wdata <= store_word;
               ram_we    <= 1'b1;
               state_reg <= WRITE;
            end
            WRITE: begin
               ram_we     <= 1'b0;
               resp_valid <= 1'b1;
               state_reg  <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a byte-array RAM model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        ram_we;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mem [1024];
   logic        preloaded = 1'b0;
   int          we_count = 0;
   logic [9:0]  last_we_addr;
   logic [31:0] last_we_data;

   load_store_unit dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   always #5 clk = ~clk;

   assign ram_rdata = {mem[{ram_addr[9:2], 2'b11}], mem[{ram_addr[9:2], 2'b10}],
                       mem[{ram_addr[9:2], 2'b01}], mem[{ram_addr[9:2], 2'b00}]};

   always @(posedge clk) begin
      if (!preloaded) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
         mem[16] <= 8'h21; mem[17] <= 8'h43; mem[18] <= 8'h65; mem[19] <= 8'h87;
         mem[32] <= 8'h44; mem[33] <= 8'h33; mem[34] <= 8'h22; mem[35] <= 8'h11;
         preloaded <= 1'b1;
      end else if (ram_we) begin
         mem[{ram_addr[9:2], 2'b00}] <= ram_wdata[7:0];
         mem[{ram_addr[9:2], 2'b01}] <= ram_wdata[15:8];
         mem[{ram_addr[9:2], 2'b10}] <= ram_wdata[23:16];
         mem[{ram_addr[9:2], 2'b11}] <= ram_wdata[31:24];
      end
   end

   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         we_count++;
         last_we_addr = ram_addr;
         last_we_data = ram_wdata;
      end
   end

   task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat, output logic [31:0] rd,
                          output logic er);
      int guard;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
      $display("txn we=%0b f3=%03b addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
               we, f3, addr, wd, rd, er, lat);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
      resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 ||
          ram_we !== 1'b0 || ram_addr !== 10'h0 || ram_wdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_values: rdy=%b vld=%b rd=%h err=%b we=%b addr=%h wd=%h, required 1 0 0 0 0 0 0",
                  req_ready, resp_valid, resp_rdata, resp_err, ram_we, ram_addr, ram_wdata);
      end
      rst = 1'b1;
   endtask

   task automatic test_word_load();
      int lat; logic [31:0] rd; logic er; int w0;
      w0 = we_count;
      run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
      checks++;
      if (rd !== 32'h87654321 || er !== 1'b0 || lat != 1 || we_count != w0) begin
         errors++;
         $display("FAIL lw_0x10: rdata=%h err=%b lat=%0d we_pulses=%0d, required 87654321 0 1 0",
                  rd, er, lat, we_count - w0);
      end
   endtask

   task automatic test_subword_loads();
      logic [2:0]  f3s  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
      logic [31:0] exps [4] = '{32'hFFFFFF87, 32'h00000087, 32'hFFFF8765, 32'h00004321};
      int lat; logic [31:0] rd; logic er;
      for (int i = 0; i < 4; i++) begin
         run_req(1'b0, f3s[i], adrs[i], 32'h0, lat, rd, er);
         checks++;
         if (rd !== exps[i] || er !== 1'b0 || lat != 1) begin
            errors++;
            $display("FAIL subword_load_%0d: rdata=%h err=%b lat=%0d, required %h 0 1",
                     i, rd, er, lat, exps[i]);
         end
      end
   endtask

   task automatic test_sub_stores();
      int lat; logic [31:0] rd; logic er; int w0;
      w0 = we_count;
      run_req(1'b1, 3'b000, 32'h11, 32'h123456AA, lat, rd, er);
      checks++;
      if (we_count - w0 != 1 || last_we_addr !== 10'h010 || last_we_data !== 32'h8765AA21 ||
          lat != 2 || rd !== 32'h0 || er !== 1'b0) begin
         errors++;
         $display("FAIL sb_0x11: pulses=%0d addr=%h wdata=%h lat=%0d rdata=%h err=%b, required 1 010 8765aa21 2 0 0",
                  we_count - w0, last_we_addr, last_we_data, lat, rd, er);
      end
      run_req(1'b0, 3'b010, 32'h10, 32'h0, lat, rd, er);
      checks++;
      if (rd !== 32'h8765AA21) begin
         errors++;
         $display("FAIL lw_after_sb: rdata=%h, required 8765aa21", rd);
      end
      w0 = we_count;
      run_req(1'b1, 3'b001, 32'h12, 32'h0000BEEF, lat, rd, er);
      checks++;
      if (we_count - w0 != 1 || last_we_data !== 32'hBEEFAA21 || lat != 2 || er !== 1'b0) begin
         errors++;
         $display("FAIL sh_0x12: pulses=%0d wdata=%h lat=%0d err=%b, required 1 beefaa21 2 0",
                  we_count - w0, last_we_data, lat, er);
      end
   endtask

   task automatic test_word_store();
      int lat; logic [31:0] rd; logic er; int w0;
      w0 = we_count;
      run_req(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, lat, rd, er);
      checks++;
      if (we_count - w0 != 1 || last_we_addr !== 10'h030 || last_we_data !== 32'hCAFEF00D ||
          lat != 1 || er !== 1'b0) begin
         errors++;
         $display("FAIL sw_0x30: pulses=%0d addr=%h wdata=%h lat=%0d err=%b, required 1 030 cafef00d 1 0",
                  we_count - w0, last_we_addr, last_we_data, lat, er);
      end
      run_req(1'b0, 3'b010, 32'h30, 32'h0, lat, rd, er);
      checks++;
      if (rd !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL lw_after_sw: rdata=%h, required cafef00d", rd);
      end
   endtask

   task automatic test_errors();
      logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0]  f3s  [5] = '{3'b010, 3'b001, 3'b000, 3'b011, 3'b100};
      logic [31:0] adrs [5] = '{32'h12, 32'h11, 32'h400, 32'h10, 32'h10};
      int lat; logic [31:0] rd; logic er; int w0;
      for (int i = 0; i < 5; i++) begin
         w0 = we_count;
         run_req(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, lat, rd, er);
         checks++;
         if (er !== 1'b1 || rd !== 32'h0 || lat != 0 || we_count != w0) begin
            errors++;
            $display("FAIL error_case_%0d: err=%b rdata=%h lat=%0d pulses=%0d, required 1 0 0 0",
                     i, er, rd, lat, we_count - w0);
         end
      end
   endtask

   task automatic test_back_to_back();
      int guard;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = '0;
      @(posedge clk); #1;
      req_funct3 = 3'b000; req_addr = 32'h13;
      guard = 0;
      while (resp_valid !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      checks++;
      if (guard != 1) begin
         errors++;
         $display("FAIL bp_latency: lat=%0d, required 1", guard);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (resp_valid !== 1'b1 || resp_rdata !== 32'hBEEFAA21 || resp_err !== 1'b0 ||
             req_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: vld=%b rdata=%h err=%b rdy=%b, required 1 beefaa21 0 0",
                     i, resp_valid, resp_rdata, resp_err, req_ready);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_handshake: vld=%b rdy=%b, required 0 1", resp_valid, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_second_accept: rdy=%b, required 0", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFFFFBE) begin
         errors++;
         $display("FAIL bp_second_resp: vld=%b rdata=%h, required 1 ffffffbe", resp_valid, resp_rdata);
      end
      $display("txn back_to_back lw 0x10 then lb 0x13 -> rdata=%08h", resp_rdata);
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      int lat; logic [31:0] rd; logic er; int w0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      w0 = we_count;
      checks++;
      if (ram_we !== 1'b1) begin
         errors++;
         $display("FAIL rst_in_write_we: ram_we=%b, required 1", ram_we);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ram_we !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
          resp_err !== 1'b0 || ram_addr !== 10'h0 || ram_wdata !== 32'h0) begin
         errors++;
         $display("FAIL rst_in_write_outputs: we=%b rdy=%b vld=%b rd=%h err=%b addr=%h wd=%h, required 0 1 0 0 0 0 0",
                  ram_we, req_ready, resp_valid, resp_rdata, resp_err, ram_addr, ram_wdata);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      checks++;
      if ({mem[35], mem[34], mem[33], mem[32]} !== 32'h11223344 || we_count != w0) begin
         errors++;
         $display("FAIL rst_in_write_ram: word=%h pulses=%0d, required 11223344 0",
                  {mem[35], mem[34], mem[33], mem[32]}, we_count - w0);
      end
      $display("txn reset during sw 0x20");
      run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, rd, er);
      checks++;
      if (rd !== 32'h11223344 || er !== 1'b0 || lat != 1) begin
         errors++;
         $display("FAIL lw_after_reset: rdata=%h err=%b lat=%0d, required 11223344 0 1", rd, er, lat);
      end
   endtask

   initial begin
      test_reset();
      test_word_load();
      test_subword_loads();
      test_sub_stores();
      test_word_store();
      test_errors();
      test_back_to_back();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
